md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Multi-cycle HI/LO unit for the 5-stage MIPS pipeline. Executes MULT/MULTU/DIV/DIVU iteratively and services MFHI/MFLO/MTHI/MTLO.
- Sits beside the EX-stage ALU. Takes the funct field and operands from ID/EX.
- Raises `stall` to the hazard logic whenever an HI/LO instruction conflicts with an operation still in flight.

Parameters:
- XLEN, 32, operand width. HI and LO are each XLEN bits. The iteration count equals XLEN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low
- md_valid  in  1  EX-stage instruction is R-type (OpCode 0) and valid
- funct  in  6  Funct field of the EX-stage instruction
- rs_data  in  XLEN  forwarded rs operand
- rt_data  in  XLEN  forwarded rt operand
- flush  in  1  kill the EX-stage instruction this cycle; gates issue only
- stall  out  1  hold IF/ID/EX and bubble EX/MEM (combinational)
- busy  out  1  operation in flight (registered)
- mf_data  out  XLEN  MFHI/MFLO result for the EX/MEM register (combinational)
- hi  out  XLEN  architectural HI
- lo  out  XLEN  architectural LO

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, hi=lo=0, cnt=0, busy=0.
  - Aborts any in-flight operation, with no partial HI/LO write.
  - stall is 0 while in IDLE.
- Decoded funct values:
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU (start ops).
  - 0x10 MFHI, 0x12 MFLO, 0x11 MTHI, 0x13 MTLO.
  - Any other funct, or md_valid=0, or flush=1: no effect, stall=0.
- md_hit = md_valid && !flush && funct is one of the 8 values above.
- stall = md_hit && state!=IDLE. This covers a new start, any MF, or any MT while MUL/DIV/FIX is active.
- States and transitions:
  - IDLE -> MUL or DIV on an accepted start.
  - MUL/DIV -> FIX when cnt==XLEN-1.
  - FIX -> IDLE unconditionally.
- Issue (IDLE, md_hit, start op), at the edge:
  - Latch |rs| and |rt| for signed ops (raw values for unsigned ops).
  - Latch the sign flags and the divisor-zero flag; clear cnt.
- MUL, one iteration per cycle: radix-2 shift-add into a 2*XLEN accumulator; cnt++.
- DIV, one iteration per cycle: restoring, one quotient bit per cycle; remainder is XLEN+1 bits; cnt++.
- FIX, one cycle, writes HI/LO:
  - Signed MULT: negate the 64-bit product when sign_rs^sign_rt.
  - Signed DIV: quotient sign = sign_rs^sign_rt; remainder sign = sign_rs.
  - DIV(U) with divisor 0: HI=rs as issued, LO=all ones. Latency is unchanged.
  - DIV 0x80000000 / -1: LO=0x80000000, HI=0. This falls out of the magnitude algorithm.
  - Result placement: product HI=upper half, LO=lower half; divide LO=quotient, HI=remainder.
- Timing: issue at cycle 0, iterations in cycles 1..XLEN, FIX in cycle XLEN+1. New HI/LO are visible from cycle XLEN+2 (34 for XLEN=32). busy=1 in cycles 1..XLEN+1.
- MFHI/MFLO in IDLE: mf_data=hi/lo in the same cycle, no stall.
- mf_data is 0 whenever no MF is hitting.
- MTHI/MTLO in IDLE: hi/lo<=rs_data at the edge. An MF in the next cycle sees the new value.
- Issue is accepted only in IDLE, so a start and a FIX write can never collide.
- An op stalled in FIX is accepted in the following IDLE cycle.
- flush together with a start: no start, busy stays 0, hi/lo unchanged.
- flush has no effect on an operation already in flight; it always completes.
- Operands must be held stable while stall=1. Only the issue-cycle values are used.

Decomposition:
- Shared package md_pkg holds:
  - XLEN default.
  - Funct constants: FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO.
  - State enum: IDLE, MUL, DIV, FIX.
- Sub-module md_iter_step: purely combinational one-iteration datapath.
  - Inputs: mode (mul/div), accumulator/remainder, quotient, multiplicand/divisor.
  - Outputs: next accumulator/remainder and quotient.
  - The sequencer owns all registers, the counter, sign fix-up and the FSM.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3 issued at cycle 0 -> busy=1 in cycles 1..33; at cycle 34 HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Three divides:
  - DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/0 -> HI=7, LO=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT 6x7 at cycle 0, MFLO presented from cycle 1 -> stall=1 in cycles 1..33; at cycle 34 stall=0 and mf_data=42. A MULT presented during busy stalls identically.
- MTHI rs=0x12345678 in IDLE, MFHI next cycle -> mf_data=0x12345678, stall never asserted. MULT with flush=1 -> busy stays 0, HI/LO unchanged.
- DIV issued, reset driven 0 at cycle 10 -> at cycle 11 busy=0, hi=lo=0, state IDLE. A following MFLO returns 0 with no stall.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: width, funct codes, FSM states.
package md_pkg;

   localparam int XLEN = 32;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdState_e;

   function automatic logic isMdFunct(input logic [5:0] f);
      return f inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                       FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
   endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// EX-stage <-> HI/LO unit signal bundle; master is the pipeline side, slave the sequencer.
interface md_sequencer_if #(parameter int XLEN = md_pkg::XLEN);
   // A request is md_valid && !flush with an HI/LO funct; it is taken on the first
   // clk edge where stall is low, and funct/operands must stay put while stall is high.
   logic            md_valid;
   logic [5:0]      funct;
   logic [XLEN-1:0] rs_data;
   logic [XLEN-1:0] rt_data;
   logic            flush;
   logic            stall;
   logic            busy;
   logic [XLEN-1:0] mf_data;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (output md_valid, funct, rs_data, rt_data, flush,
                   input  stall, busy, mf_data, hi, lo);
   modport slave  (input  md_valid, funct, rs_data, rt_data, flush,
                   output stall, busy, mf_data, hi, lo);
endinterface

// File: rtl/md_sequencer_iter_step.sv
// One iteration of radix-2 shift-add multiply or restoring divide; purely combinational.
module md_iter_step import md_pkg::*; #(
   parameter int XLEN = md_pkg::XLEN
) (
   input  logic            divMode,
   input  logic [XLEN:0]   remIn,
   input  logic [XLEN-1:0] quoIn,
   input  logic [XLEN-1:0] opIn,
   output logic [XLEN:0]   remOut,
   output logic [XLEN-1:0] quoOut
);
   logic [XLEN:0] addSum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   // Multiply keeps {product high, product low/multiplier} in {remIn, quoIn}.
   always_comb begin
      addSum  = {1'b0, remIn[XLEN-1:0]} + (quoIn[0] ? {1'b0, opIn} : '0);
      shifted = {remIn[XLEN-1:0], quoIn[XLEN-1]};
      trial   = shifted - {1'b0, opIn};
      remOut  = {1'b0, addSum[XLEN:1]};
      quoOut  = {addSum[0], quoIn[XLEN-1:1]};
      if (divMode) begin
         if (shifted >= {1'b0, opIn}) begin
            remOut = trial;
            quoOut = {quoIn[XLEN-2:0], 1'b1};
         end else begin
            remOut = shifted;
            quoOut = {quoIn[XLEN-2:0], 1'b0};
         end
      end
   end
endmodule

// File: rtl/md_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MF/MT service and EX-stage stall.
module md_sequencer import md_pkg::*; (
   input  logic          clk,
   input  logic          reset,
   md_sequencer_if.slave bus,
   output mdState_e      dbgState
);
   localparam int CNT_W = $clog2(XLEN);

   mdState_e          state, stateNext;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN:0]     remReg, remStep;
   logic [XLEN-1:0]   quoReg, quoStep, opReg;
   logic [XLEN-1:0]   hiReg, loReg;
   logic              signRs, signRt, divZero, opIsDiv, busyReg;
   logic              mdHit, issue, isSigned, startDiv, lastIter;
   logic [XLEN-1:0]   absRs, absRt, quoFix, remFix;
   logic [2*XLEN-1:0] prodFix;

   always_comb begin
      mdHit    = bus.md_valid && !bus.flush && isMdFunct(bus.funct);
      issue    = mdHit && (state == IDLE) &&
                 (bus.funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
      isSigned = (bus.funct == FN_MULT) || (bus.funct == FN_DIV);
      startDiv = (bus.funct == FN_DIV) || (bus.funct == FN_DIVU);
      absRs    = (isSigned && bus.rs_data[XLEN-1]) ? -bus.rs_data : bus.rs_data;
      absRt    = (isSigned && bus.rt_data[XLEN-1]) ? -bus.rt_data : bus.rt_data;
      lastIter = (cnt == CNT_W'(XLEN-1));
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:     if (issue) stateNext = startDiv ? DIV : MUL;
         MUL, DIV: if (lastIter) stateNext = FIX;
         FIX:      stateNext = IDLE;
         default:  stateNext = IDLE;
      endcase
   end

   // Divide-by-zero naturally leaves |rs| in the remainder, so only LO needs forcing.
   always_comb begin
      prodFix = {remReg[XLEN-1:0], quoReg};
      if (signRs ^ signRt) prodFix = -prodFix;
      quoFix = (signRs ^ signRt) ? -quoReg : quoReg;
      if (divZero) quoFix = '1;
      remFix = signRs ? -remReg[XLEN-1:0] : remReg[XLEN-1:0];
   end

   always_comb begin
      bus.mf_data = '0;
      if (mdHit && state == IDLE) begin
         if (bus.funct == FN_MFHI)      bus.mf_data = hiReg;
         else if (bus.funct == FN_MFLO) bus.mf_data = loReg;
      end
   end

   md_iter_step #(.XLEN(XLEN)) uStep (
      .divMode (state == DIV),
      .remIn   (remReg),
      .quoIn   (quoReg),
      .opIn    (opReg),
      .remOut  (remStep),
      .quoOut  (quoStep)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         busyReg <= 1'b0;
         cnt     <= '0;
         remReg  <= '0;
         quoReg  <= '0;
         opReg   <= '0;
         hiReg   <= '0;
         loReg   <= '0;
         signRs  <= 1'b0;
         signRt  <= 1'b0;
         divZero <= 1'b0;
         opIsDiv <= 1'b0;
      end else begin
         state   <= stateNext;
         busyReg <= (stateNext != IDLE);
         case (state)
            IDLE: begin
               if (issue) begin
                  cnt     <= '0;
                  remReg  <= '0;
                  quoReg  <= startDiv ? absRs : absRt;
                  opReg   <= startDiv ? absRt : absRs;
                  signRs  <= isSigned && bus.rs_data[XLEN-1];
                  signRt  <= isSigned && bus.rt_data[XLEN-1];
                  divZero <= (bus.rt_data == '0);
                  opIsDiv <= startDiv;
               end else if (mdHit && bus.funct == FN_MTHI) begin
                  hiReg <= bus.rs_data;
               end else if (mdHit && bus.funct == FN_MTLO) begin
                  loReg <= bus.rs_data;
               end
            end
            MUL, DIV: begin
               remReg <= remStep;
               quoReg <= quoStep;
               cnt    <= cnt + 1'b1;
            end
            FIX: begin
               if (opIsDiv) begin
                  hiReg <= remFix;
                  loReg <= quoFix;
               end else begin
                  hiReg <= prodFix[2*XLEN-1:XLEN];
                  loReg <= prodFix[XLEN-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.stall = mdHit && (state != IDLE);
   assign bus.busy  = busyReg;
   assign bus.hi    = hiReg;
   assign bus.lo    = loReg;
   assign dbgState  = state;
endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer: latency, signed/unsigned results, stalls, MT/MF, flush, reset abort.
module tb_md_sequencer;
   import md_pkg::*;

   logic     clk;
   logic     reset;
   mdState_e dbgState;
   int       nAsserts = 0;
   int       nFail = 0;

   md_sequencer_if bus ();

   md_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .dbgState (dbgState)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] rs,
                        input logic [31:0] rt, input logic fl);
      bus.md_valid = v;
      bus.funct    = f;
      bus.rs_data  = rs;
      bus.rt_data  = rt;
      bus.flush    = fl;
   endtask

   // Presents a start op in an IDLE cycle (cycle 0) and returns in cycle 1 with inputs idle.
   task automatic issueOp(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
      drive(1'b1, f, rs, rt, 1'b0);
      sample();
      check("issue_stall", 32'(bus.stall), 32'd0);
      nextCycle();
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
   endtask

   // Waits (bounded) for busy to drop; results must appear exactly in cycle 34.
   task automatic finishOp(input string tag, input int startCyc,
                           input logic [31:0] expHi, input logic [31:0] expLo);
      int cyc;
      cyc = startCyc;
      sample();
      while (bus.busy === 1'b1 && cyc < 40) begin
         nextCycle();
         cyc++;
         sample();
      end
      check({tag, "_latency"}, 32'(cyc), 32'd34);
      check({tag, "_hi"}, bus.hi, expHi);
      check({tag, "_lo"}, bus.lo, expLo);
   endtask

   // Holds a request while stalled (bounded); the stall must lift exactly in cycle 34.
   task automatic waitStall(input string tag);
      int cyc;
      cyc = 1;
      sample();
      check({tag, "_stall_c1"}, 32'(bus.stall), 32'd1);
      while (bus.stall === 1'b1 && cyc < 40) begin
         nextCycle();
         cyc++;
         sample();
      end
      check({tag, "_release_cycle"}, 32'(cyc), 32'd34);
   endtask

   initial begin
      // Reset: MFLO presented during reset must not stall and must read 0.
      reset = 1'b0;
      drive(1'b1, FN_MFLO, 32'd0, 32'd0, 1'b0);
      nextCycle();
      nextCycle();
      sample();
      check("rst_state", 32'(dbgState), 32'(IDLE));
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_mf", bus.mf_data, 32'd0);
      nextCycle();
      reset = 1'b1;
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
      nextCycle();

      // Arithmetic results and latency.
      issueOp(FN_MULT, 32'hFFFFFFFE, 32'd3);
      finishOp("mult_neg", 1, 32'hFFFFFFFF, 32'hFFFFFFFA);
      nextCycle();
      issueOp(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      finishOp("multu_max", 1, 32'hFFFFFFFE, 32'h00000001);
      nextCycle();
      issueOp(FN_DIV, 32'hFFFFFFF9, 32'd2);
      finishOp("div_neg", 1, 32'hFFFFFFFF, 32'hFFFFFFFD);
      nextCycle();
      issueOp(FN_DIVU, 32'd7, 32'd0);
      finishOp("divu_zero", 1, 32'd7, 32'hFFFFFFFF);
      nextCycle();
      issueOp(FN_DIV, 32'h80000000, 32'hFFFFFFFF);
      finishOp("div_ovf", 1, 32'd0, 32'h80000000);
      nextCycle();
      issueOp(FN_DIV, 32'hFFFFFFF9, 32'd0);
      finishOp("div_zero_neg", 1, 32'hFFFFFFF9, 32'hFFFFFFFF);
      nextCycle();
      issueOp(FN_MULT, 32'h80000000, 32'h80000000);
      finishOp("mult_minmin", 1, 32'h40000000, 32'h00000000);
      nextCycle();

      // MFLO behind an in-flight MULT.
      issueOp(FN_MULT, 32'd6, 32'd7);
      drive(1'b1, FN_MFLO, 32'd0, 32'd0, 1'b0);
      waitStall("mflo_wait");
      check("mflo_wait_data", bus.mf_data, 32'd42);
      nextCycle();
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);

      // MULT behind an in-flight DIVU, accepted in the first IDLE cycle.
      issueOp(FN_DIVU, 32'd100, 32'd7);
      drive(1'b1, FN_MULT, 32'd5, 32'd5, 1'b0);
      waitStall("mult_wait");
      check("mult_wait_div_hi", bus.hi, 32'd2);
      check("mult_wait_div_lo", bus.lo, 32'd14);
      nextCycle();
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
      finishOp("mult_after", 1, 32'd0, 32'd25);
      nextCycle();

      // MTHI/MTLO then MF in the following cycle.
      drive(1'b1, FN_MTHI, 32'h12345678, 32'd0, 1'b0);
      sample();
      check("mthi_stall", 32'(bus.stall), 32'd0);
      nextCycle();
      drive(1'b1, FN_MFHI, 32'd0, 32'd0, 1'b0);
      sample();
      check("mfhi_data", bus.mf_data, 32'h12345678);
      check("mfhi_stall", 32'(bus.stall), 32'd0);
      nextCycle();
      drive(1'b1, FN_MTLO, 32'hCAFEF00D, 32'd0, 1'b0);
      nextCycle();
      drive(1'b1, FN_MFLO, 32'd0, 32'd0, 1'b0);
      sample();
      check("mflo_data", bus.mf_data, 32'hCAFEF00D);
      nextCycle();

      // Flushed start and flushed/unknown MF have no effect.
      drive(1'b1, FN_MULT, 32'd3, 32'd3, 1'b1);
      sample();
      check("flush_start_stall", 32'(bus.stall), 32'd0);
      nextCycle();
      drive(1'b1, FN_MFHI, 32'd0, 32'd0, 1'b1);
      sample();
      check("flush_start_busy", 32'(bus.busy), 32'd0);
      check("flush_start_hi", bus.hi, 32'h12345678);
      check("flush_start_lo", bus.lo, 32'hCAFEF00D);
      check("flush_mf_data", bus.mf_data, 32'd0);
      nextCycle();
      drive(1'b1, 6'h20, 32'd0, 32'd0, 1'b0);
      sample();
      check("other_funct_mf", bus.mf_data, 32'd0);
      nextCycle();

      // Flush and unrelated funct during a divide neither stall nor abort it.
      issueOp(FN_DIV, 32'hFFFFFF9C, 32'd7);
      drive(1'b1, FN_MFLO, 32'd0, 32'd0, 1'b1);
      sample();
      check("flush_busy_stall", 32'(bus.stall), 32'd0);
      nextCycle();
      drive(1'b1, 6'h20, 32'd0, 32'd0, 1'b0);
      sample();
      check("other_busy_stall", 32'(bus.stall), 32'd0);
      nextCycle();
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
      finishOp("div_flushed", 3, 32'hFFFFFFFE, 32'hFFFFFFF2);
      nextCycle();

      // Reset in cycle 10 of a divide aborts it and clears HI/LO.
      issueOp(FN_DIV, 32'd1000, 32'd3);
      repeat (9) nextCycle();
      reset = 1'b0;
      nextCycle();
      reset = 1'b1;
      drive(1'b1, FN_MFLO, 32'd0, 32'd0, 1'b0);
      sample();
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_hi", bus.hi, 32'd0);
      check("abort_lo", bus.lo, 32'd0);
      check("abort_state", 32'(dbgState), 32'(IDLE));
      check("abort_mf_data", bus.mf_data, 32'd0);
      check("abort_mf_stall", 32'(bus.stall), 32'd0);
      nextCycle();
      drive(1'b0, 6'h00, 32'd0, 32'd0, 1'b0);
      sample();
      check("abort_stays_idle", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end
endmodule
